// File: rtl/tx_seq_pkg.sv
// tx_seq_pkg: shared types and widths for the transmit sequencer
// Contents: state encoding (IDLE/LEAD/PLAY/LAG), default address width, guard counter width.
package tx_seq_pkg;
    localparam int TX_ADDR_W = 14;
    localparam int TX_GUARD_W = 16;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        PLAY = 2'd2,
        LAG  = 2'd3
    } tx_state_t;
endpackage

// File: rtl/tx_guard_cnt.sv
// tx_guard_cnt: loadable down-counter timing the PA lead/lag guard intervals
// Ports: clk, rst (async, active-high), load/load_val (preset count),
//        en (count while in a guard state), done (en and count reached zero).
module tx_guard_cnt
    import tx_seq_pkg::*;
#(
    parameter int W = TX_GUARD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign done = en && cnt == '0;
endmodule

// File: rtl/tx_sequencer.sv
// tx_sequencer: trigger-driven DAC address sequencer with PA lead/lag guarding
// Ports: clk, rst (async, active-high), trig (start request), txsmps (samples per pulse),
//        tx_addr/tx_valid (waveform address to DAC), pa_en (PA enable), busy (not IDLE),
//        overruns (ignored-trigger count, only with TX_SEQ_OVERRUN_CNT_EN defined).
// Outputs are registered decodes of the current state, so they trail the state by one edge.
module tx_sequencer
    import tx_seq_pkg::*;
#(
    parameter int ADDR_W  = TX_ADDR_W,
    parameter int PA_LEAD = 64,
    parameter int PA_LAG  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [ADDR_W-1:0] txsmps,
    output logic [ADDR_W-1:0] tx_addr,
    output logic              tx_valid,
    output logic              pa_en,
    output logic              busy
`ifdef TX_SEQ_OVERRUN_CNT_EN
    ,
    output logic [15:0]       overruns
`endif
);
    localparam logic [TX_GUARD_W-1:0] LEAD_LD = TX_GUARD_W'(PA_LEAD - 1);
    localparam logic [TX_GUARD_W-1:0] LAG_LD  = TX_GUARD_W'(PA_LAG - 1);

    tx_state_t             state, state_nxt;
    logic [ADDR_W-1:0]     n_reg, addr;
    logic                  accept, last, g_load, g_en, g_done;
    logic [TX_GUARD_W-1:0] g_val;

    assign accept = state == IDLE && trig && txsmps != '0;
    assign last   = addr == n_reg - ADDR_W'(1);
    assign g_en   = state == LEAD || state == LAG;

    tx_guard_cnt #(.W(TX_GUARD_W)) u_guard (
        .clk      (clk),
        .rst      (rst),
        .load     (g_load),
        .load_val (g_val),
        .en       (g_en),
        .done     (g_done)
    );

    always_comb begin
        state_nxt = state;
        g_load    = 1'b0;
        g_val     = LEAD_LD;
        case (state)
            IDLE: if (accept) begin
                state_nxt = LEAD;
                g_load    = 1'b1;
            end
            LEAD: if (g_done) state_nxt = PLAY;
            PLAY: if (last) begin
                state_nxt = LAG;
                g_load    = 1'b1;
                g_val     = LAG_LD;
            end
            LAG:  if (g_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            n_reg <= '0;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                n_reg <= txsmps;
            addr <= (state == PLAY && !last) ? addr + ADDR_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_addr  <= '0;
            tx_valid <= 1'b0;
            pa_en    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            tx_addr  <= state == PLAY ? addr : '0;
            tx_valid <= state == PLAY;
            pa_en    <= state != IDLE;
            busy     <= state != IDLE;
        end
    end

`ifdef TX_SEQ_OVERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overruns <= '0;
        else if (trig && state != IDLE && overruns != 16'hFFFF)
            overruns <= overruns + 16'd1;
    end
`endif
endmodule

// File: tb/tb_tx_sequencer.sv
// tb_tx_sequencer: directed table-driven bench for tx_sequencer (PA_LEAD=4, PA_LAG=3)
module tb_tx_sequencer;
    localparam int L = 4;
    localparam int G = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic [13:0] txsmps = '0;
    logic [13:0] tx_addr;
    logic        tx_valid, pa_en, busy;
`ifdef TX_SEQ_OVERRUN_CNT_EN
    logic [15:0] overruns;
`endif

    int checks = 0;
    int errors = 0;

    tx_sequencer #(.ADDR_W(14), .PA_LEAD(L), .PA_LAG(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .trig     (trig),
        .txsmps   (txsmps),
        .tx_addr  (tx_addr),
        .tx_valid (tx_valid),
        .pa_en    (pa_en),
        .busy     (busy)
`ifdef TX_SEQ_OVERRUN_CNT_EN
        ,
        .overruns (overruns)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        trig;
        logic [13:0] smps;
        logic        pa;
        logic        val;
        logic [13:0] addr;
        logic        busy;
        logic [15:0] ovr;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic pa, input logic val, input logic [13:0] addr, input logic bsy);
        chk({tag, " pa_en"}, 32'(pa_en), 32'(pa));
        chk({tag, " tx_valid"}, 32'(tx_valid), 32'(val));
        chk({tag, " tx_addr"}, 32'(tx_addr), 32'(addr));
        chk({tag, " busy"}, 32'(busy), 32'(bsy));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        trig = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_pulse(input int n, input string tag);
        txsmps = 14'(n);
        for (int i = 0; i <= L + n + G + 1; i++) begin
            trig = (i == 0);
            step();
            chk_out($sformatf("%s c%0d", tag, i),
                    i >= 1 && i <= L + n + G,
                    i >= L + 1 && i <= L + n,
                    (i >= L + 1 && i <= L + n) ? 14'(i - L - 1) : 14'd0,
                    i >= 1 && i <= L + n + G);
        end
        trig = 1'b0;
    endtask

    initial begin
        int nv, bad, lag_pa;
        bit found, done1;
        vt[0]  = '{1, 5, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 9, 1, 0, 0, 1, 0};
        vt[2]  = '{0, 9, 1, 0, 0, 1, 0};
        vt[3]  = '{0, 9, 1, 0, 0, 1, 0};
        vt[4]  = '{0, 9, 1, 0, 0, 1, 0};
        vt[5]  = '{0, 9, 1, 1, 0, 1, 0};
        vt[6]  = '{0, 9, 1, 1, 1, 1, 0};
        vt[7]  = '{1, 9, 1, 1, 2, 1, 1};
        vt[8]  = '{0, 9, 1, 1, 3, 1, 1};
        vt[9]  = '{0, 9, 1, 1, 4, 1, 1};
        vt[10] = '{0, 9, 1, 0, 0, 1, 1};
        vt[11] = '{0, 9, 1, 0, 0, 1, 1};
        vt[12] = '{1, 9, 1, 0, 0, 1, 2};
        vt[13] = '{0, 9, 0, 0, 0, 0, 2};
        vt[14] = '{0, 9, 0, 0, 0, 0, 2};
        vt[15] = '{0, 9, 0, 0, 0, 0, 2};
        vt[16] = '{1, 0, 0, 0, 0, 0, 2};
        vt[17] = '{1, 0, 0, 0, 0, 0, 2};
        vt[18] = '{0, 0, 0, 0, 0, 0, 2};

        step();
        chk_out("reset", 0, 0, 0, 0);
`ifdef TX_SEQ_OVERRUN_CNT_EN
        chk("reset overruns", 32'(overruns), 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            trig = vt[i].trig;
            txsmps = vt[i].smps;
            step();
            chk_out($sformatf("tbl c%0d", i), vt[i].pa, vt[i].val, vt[i].addr, vt[i].busy);
`ifdef TX_SEQ_OVERRUN_CNT_EN
            chk($sformatf("tbl c%0d overruns", i), 32'(overruns), 32'(vt[i].ovr));
`endif
        end
        trig = 1'b0;

        do_reset();
        txsmps = 14'd2;
        trig = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            step();
            chk_out($sformatf("held c%0d", i), (i % 10) != 0,
                    (i % 10) == 5 || (i % 10) == 6,
                    ((i % 10) == 5 || (i % 10) == 6) ? 14'((i % 10) - 5) : 14'd0,
                    (i % 10) != 0);
        end
        trig = 1'b0;
        for (int i = 0; i < 12; i++) step();

        do_reset();
        txsmps = 14'd5;
        trig = 1'b1;
        step();
        trig = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = tx_valid && tx_addr == 14'd3;
        end
        chk("midplay reached addr3", 32'(found), 1);
        rst = 1'b1;
        #1;
        chk_out("async rst", 0, 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        run_pulse(3, "post rst");

        do_reset();
        txsmps = 14'd16383;
        trig = 1'b1;
        nv = 0;
        bad = 0;
        lag_pa = 0;
        done1 = 0;
        for (int i = 0; i < 70000; i++) begin
            step();
            if (!done1) begin
                if (tx_valid) begin
                    if (tx_addr != 14'(nv)) bad++;
                    nv++;
                end else if (nv > 0) begin
                    done1 = 1;
                    lag_pa = int'(pa_en);
                end
            end
        end
        trig = 1'b0;
        chk("long sample count", 32'(nv), 16383);
        chk("long addr gaps", 32'(bad), 0);
        chk("long lag pa_en", 32'(lag_pa), 1);
`ifdef TX_SEQ_OVERRUN_CNT_EN
        chk("overruns saturate", 32'(overruns), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
